mdu_cdb_fifo: RTL and testbench

MDU_CDB_FIFO -- requirements
Module: mdu_cdb_fifo

---
 rtl/mdu_cdb_fifo.sv | 96 +++++++++
 tb/tb_mdu_cdb_fifo.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/mdu_cdb_fifo.sv
`default_nettype none
// ============================================================================
// Module      : mdu_cdb_fifo (with mdu_cdb_pkg)
// Description : Small circular result buffer between the MDU issue stage and
//               the CDB arbiter. It presents the oldest entry first-word-
//               fallthrough, and its ready/valid outputs are purely registered.
// Revision    : 1.0 - initial release
// ============================================================================

package mdu_cdb_pkg;
    // Result broadcast on the common data bus
    typedef struct packed {
        logic        valid;
        logic [5:0]  rob_id;
        logic [31:0] data;
    } cdb_info_t;
endpackage

module mdu_cdb_fifo
    import mdu_cdb_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int PTR_LEN = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  cdb_info_t          result_i,
    input  logic               valid_i,
    output logic               ready_o,
    output cdb_info_t          result_o,
    output logic               valid_o,
    input  logic               ready_i,
    output logic [PTR_LEN:0]   count_o
);

    localparam logic [PTR_LEN:0]   c_FULL    = (PTR_LEN+1)'(DEPTH);
    localparam logic [PTR_LEN:0]   c_CNT_ONE = (PTR_LEN+1)'(1);
    localparam logic [PTR_LEN-1:0] c_PTR_ONE = PTR_LEN'(1);

    cdb_info_t          r_mem [DEPTH];
    logic [PTR_LEN-1:0] r_head;
    logic [PTR_LEN-1:0] r_tail;
    logic [PTR_LEN:0]   r_count;

    logic w_push;
    logic w_pop;

    // Handshake flags come only from the occupancy register, so neither
    // ready_o nor valid_o has a combinational path from the other side.
    assign ready_o = (r_count != c_FULL);
    assign valid_o = (r_count != '0);
    assign count_o = r_count;

    // A full buffer refuses writes even if it pops this cycle; an empty one
    // ignores ready_i. Both fall out of the registered flags above.
    assign w_push = valid_i & ready_o;
    assign w_pop  = valid_o & ready_i;

    // Array contents are never exposed while empty, so they need no reset.
    assign result_o = valid_o ? r_mem[r_head] : '0;

    // Pointer and occupancy update; flush wins over any push or pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + c_PTR_ONE;
            end
            if (w_pop) begin
                r_head <= r_head + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage write at the tail; a flushed push is dropped entirely.
    always_ff @(posedge clk) begin
        if (w_push && !flush) begin
            r_mem[r_tail] <= result_i;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mdu_cdb_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_mdu_cdb_fifo
// Description : Scoreboard bench for mdu_cdb_fifo. Accepted writes are queued
//               and compared against result_o when they are consumed.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_mdu_cdb_fifo;
    import mdu_cdb_pkg::*;

    localparam int DEPTH   = 4;
    localparam int PTR_LEN = $clog2(DEPTH);

    logic             clk;
    logic             rst_n;
    logic             flush;
    cdb_info_t        result_i;
    logic             valid_i;
    logic             ready_o;
    cdb_info_t        result_o;
    logic             valid_o;
    logic             ready_i;
    logic [PTR_LEN:0] count_o;

    int total;
    int bad;

    cdb_info_t q[$];

    mdu_cdb_fifo #(.DEPTH(DEPTH), .PTR_LEN(PTR_LEN)) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .result_i (result_i),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .result_o (result_o),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .count_o  (count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic cdb_info_t mk(input logic [5:0] id);
        cdb_info_t r;
        r.valid  = 1'b1;
        r.rob_id = id;
        r.data   = $urandom;
        return r;
    endfunction

    // Check outputs against the model queue (called between edges)
    task automatic chk_state();
        cdb_info_t exp_res;
        exp_res = (q.size() != 0) ? q[0] : '0;
        chk("count",  64'(count_o),  64'(q.size()));
        chk("valid",  64'(valid_o),  64'(q.size() != 0));
        chk("ready",  64'(ready_o),  64'(q.size() != DEPTH));
        chk("head",   64'(result_o), 64'(exp_res));
    endtask

    // One clock: model the handshake from inputs driven now, step, then check
    task automatic cycle();
        bit        mpush;
        bit        mpop;
        cdb_info_t din;
        mpush = valid_i && (q.size() != DEPTH);
        mpop  = ready_i && (q.size() != 0);
        din   = result_i;
        if (mpop) chk("pop_data", 64'(result_o), 64'(q[0]));
        @(posedge clk);
        if (flush) begin
            q.delete();
        end else begin
            if (mpop)  void'(q.pop_front());
            if (mpush) q.push_back(din);
        end
        #1;
        chk_state();
    endtask

    task automatic push_n(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            valid_i  = 1'b1;
            result_i = mk(6'(base + i));
            cycle();
        end
        valid_i = 1'b0;
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        rst_n    = 1'b0;
        flush    = 1'b0;
        valid_i  = 1'b0;
        ready_i  = 1'b0;
        result_i = '0;

        // Outputs while reset is held
        #3;
        chk_state();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single push, first edge after reset, then hold for 10 cycles
        push_n(1, 5);
        chk("rob5", 64'(result_o.rob_id), 64'd5);
        repeat (10) cycle();
        chk("rob5_hold", 64'(result_o.rob_id), 64'd5);
        ready_i = 1'b1;
        cycle();
        ready_i = 1'b0;

        // Fill to full, fifth write dropped, drain in order
        push_n(4, 1);
        chk("full_ready", 64'(ready_o), 64'd0);
        push_n(1, 9);
        chk("full_cnt", 64'(count_o), 64'd4);
        ready_i = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk("order", 64'(result_o.rob_id), 64'(i));
            cycle();
        end
        ready_i = 1'b0;
        chk("drained", 64'(valid_o), 64'd0);
        cycle();

        // Push and pop together at full: push ignored
        push_n(4, 1);
        valid_i  = 1'b1;
        ready_i  = 1'b1;
        result_i = mk(6'd33);
        cycle();
        valid_i = 1'b0;
        ready_i = 1'b0;
        chk("fullpp_cnt", 64'(count_o), 64'd3);
        chk("fullpp_rdy", 64'(ready_o), 64'd1);
        ready_i = 1'b1;
        repeat (3) cycle();
        ready_i = 1'b0;

        // Streaming: one ahead, then push+pop every cycle
        push_n(1, 40);
        valid_i = 1'b1;
        ready_i = 1'b1;
        for (int i = 0; i < 3*DEPTH; i++) begin
            result_i = mk(6'(41 + i));
            cycle();
            chk("stream_cnt", 64'(count_o), 64'd1);
        end
        valid_i = 1'b0;
        cycle();
        ready_i = 1'b0;

        // Flush with a concurrent push
        push_n(3, 20);
        flush    = 1'b1;
        valid_i  = 1'b1;
        result_i = mk(6'd63);
        cycle();
        flush   = 1'b0;
        valid_i = 1'b0;
        chk("flush_cnt", 64'(count_o), 64'd0);
        cycle();
        chk("flush_gone", 64'(valid_o), 64'd0);

        // Asynchronous reset between edges with two entries
        push_n(2, 50);
        #3;
        rst_n = 1'b0;
        #1;
        q.delete();
        chk_state();
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_state();
        push_n(1, 7);
        chk("post_rst", 64'(result_o.rob_id), 64'd7);

        // Random traffic with occasional flush
        for (int i = 0; i < 300; i++) begin
            valid_i  = ($urandom_range(0, 3) != 0);
            ready_i  = ($urandom_range(0, 2) != 0);
            flush    = ($urandom_range(0, 40) == 0);
            result_i = mk(6'($urandom));
            cycle();
        end
        valid_i = 1'b0;
        ready_i = 1'b0;
        flush   = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
